// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchroniser, start-glitch rejection, parity/framing checks, break recovery.
// Optional macro UART_RX_MAJORITY_EN: each bit sample is a 2-of-3 vote instead of a single sample.
module uart_rx_param #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_MODE  = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] dout,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE, S_WAIT_HIGH
  } state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 stop_idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 frame_err_n_q;
  logic                 parity_err_n_q;
  logic                 meta_q;
  logic                 rxd_s_q;
  logic [DATA_BITS-1:0] dout_q;
  logic                 valid_q;
  logic                 frame_err_q;
  logic                 parity_err_q;
  logic                 busy_q;
  logic                 tick_c;
  logic                 smp_c;

  assign tick_c = (cnt_q == '0);

  // Two-flop synchroniser on the asynchronous line, idles high
  always_ff @(posedge CLK) begin
    if (RST) begin
      meta_q  <= 1'b1;
      rxd_s_q <= 1'b1;
    end else begin
      meta_q  <= rxd;
      rxd_s_q <= meta_q;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic s2_q;
  logic s1_q;

  // Capture the two samples preceding the bit centre for a 2-of-3 vote
  always_ff @(posedge CLK) begin
    if (RST) begin
      s2_q <= 1'b1;
      s1_q <= 1'b1;
    end else begin
      if (cnt_q == CNT_W'(2)) s2_q <= rxd_s_q;
      if (cnt_q == CNT_W'(1)) s1_q <= rxd_s_q;
    end
  end

  assign smp_c = (s2_q & s1_q) | (s2_q & rxd_s_q) | (s1_q & rxd_s_q);
`else
  assign smp_c = rxd_s_q;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      idx_q          <= '0;
      stop_idx_q     <= 1'b0;
      shift_q        <= '0;
      frame_err_n_q  <= 1'b0;
      parity_err_n_q <= 1'b0;
      dout_q         <= '0;
      valid_q        <= 1'b0;
      frame_err_q    <= 1'b0;
      parity_err_q   <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!rxd_s_q) begin
            state_q <= S_START;
            cnt_q   <= CNT_HALF;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          if (tick_c) begin
            cnt_q <= CNT_FULL;
            if (smp_c) begin
              // Line went back high before mid start bit: treat as noise
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q        <= S_DATA;
              idx_q          <= '0;
              stop_idx_q     <= 1'b0;
              frame_err_n_q  <= 1'b0;
              parity_err_n_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DATA: begin
          if (tick_c) begin
            cnt_q   <= CNT_FULL;
            shift_q <= {smp_c, shift_q[DATA_BITS-1:1]};
            if (idx_q == IDX_LAST) begin
              state_q <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_PARITY: begin
          if (tick_c) begin
            cnt_q          <= CNT_FULL;
            parity_err_n_q <= (PARITY_MODE == 2) ? ~(^shift_q ^ smp_c) : (^shift_q ^ smp_c);
            state_q        <= S_STOP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_STOP: begin
          if (tick_c) begin
            cnt_q <= CNT_FULL;
            if (!smp_c) frame_err_n_q <= 1'b1;
            if (stop_idx_q == STOP_LAST) begin
              state_q <= S_DONE;
            end else begin
              stop_idx_q <= stop_idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_DONE: begin
          dout_q       <= shift_q;
          frame_err_q  <= frame_err_n_q;
          parity_err_q <= parity_err_n_q;
          valid_q      <= 1'b1;
          if (frame_err_n_q) begin
            state_q <= S_WAIT_HIGH;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_WAIT_HIGH: begin
          // A break holds the line low; only a return to idle re-arms start detection
          if (rxd_s_q) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dout       = dout_q;
  assign valid      = valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three configurations (8N1, 8E1, 8O2) driven with directed and random frames.
module tb_uart_rx_param;

  localparam int unsigned CPB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd0 = 1'b1, rxd1 = 1'b1, rxd2 = 1'b1;
  logic [7:0] d0, d1, d2;
  logic v0, v1, v2, fe0, fe1, fe2, pe0, pe1, pe2, busy0, busy1, busy2;

  int checks = 0;
  int errors = 0;

  logic [9:0] q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) dut0 (
    .CLK(clk), .RST(rst), .rxd(rxd0), .dout(d0), .valid(v0),
    .frame_err(fe0), .parity_err(pe0), .busy(busy0));
  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) dut1 (
    .CLK(clk), .RST(rst), .rxd(rxd1), .dout(d1), .valid(v1),
    .frame_err(fe1), .parity_err(pe1), .busy(busy1));
  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(2)) dut2 (
    .CLK(clk), .RST(rst), .rxd(rxd2), .dout(d2), .valid(v2),
    .frame_err(fe2), .parity_err(pe2), .busy(busy2));

  // Record every valid pulse as {parity_err, frame_err, dout}
  always @(negedge clk) begin
    if (v0) q0.push_back({pe0, fe0, d0});
    if (v1) q1.push_back({pe1, fe1, d1});
    if (v2) q2.push_back({pe2, fe2, d2});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input int d, input logic b);
    case (d)
      0: rxd0 = b;
      1: rxd1 = b;
      default: rxd2 = b;
    endcase
  endtask

  task automatic idle(input int d, input int n);
    put(d, 1'b1);
    repeat (n) @(negedge clk);
  endtask

  // Serialise one frame; glitch inverts the line for one cycle at the centre of each data bit
  task automatic send(input int d, input logic [7:0] data, input int pmode, input logic pbit,
                      input logic [1:0] stops, input int nstop, input bit glitch);
    logic bq[$];
    bq.push_back(1'b0);
    for (int i = 0; i < 8; i++) bq.push_back(data[i]);
    if (pmode != 0) bq.push_back(pbit);
    for (int i = 0; i < nstop; i++) bq.push_back(stops[i]);
    for (int j = 0; j < bq.size(); j++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        put(d, (glitch && j >= 1 && j <= 8 && c == 8) ? ~bq[j] : bq[j]);
      end
    end
  endtask

  task automatic expect_frame(input int d, input string tag, input logic [7:0] ed,
                              input logic ef, input logic ep);
    logic [9:0] e;
    int sz;
    sz = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
    chk({tag, "_count"}, 32'(sz), 32'd1);
    if (sz > 0) begin
      e = (d == 0) ? q0.pop_front() : (d == 1) ? q1.pop_front() : q2.pop_front();
      chk({tag, "_dout"}, 32'(e[7:0]), 32'(ed));
      chk({tag, "_ferr"}, 32'(e[8]), 32'(ef));
      chk({tag, "_perr"}, 32'(e[9]), 32'(ep));
    end
    case (d)
      0: q0.delete();
      1: q1.delete();
      default: q2.delete();
    endcase
  endtask

  // Reference: correct parity bit from the population count of the data word
  function automatic logic good_parity(input int pmode, input logic [7:0] data);
    int ones;
    ones = $countones(data);
    return (pmode == 1) ? 1'(ones % 2) : 1'((ones + 1) % 2);
  endfunction

  initial begin
    logic [7:0] data;
    logic [7:0] glitch_exp;
    logic pbit, bad_p, exp_f;
    logic [1:0] stops;
    int d, pmode, nstop;

    repeat (4) @(negedge clk);
    chk("rst_dout", 32'(d0), 32'd0);
    chk("rst_valid", 32'(v0), 32'd0);
    chk("rst_ferr", 32'(fe0), 32'd0);
    chk("rst_perr", 32'(pe0), 32'd0);
    chk("rst_busy", 32'({busy0, busy1, busy2}), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 8N1 basic frame
    send(0, 8'hA5, 0, 1'b0, 2'b11, 1, 1'b0);
    idle(0, 20);
    expect_frame(0, "t1_a5", 8'hA5, 1'b0, 1'b0);
    chk("t1_busy_idle", 32'(busy0), 32'd0);

    // Even parity: wrong then right parity bit
    send(1, 8'h07, 1, 1'b0, 2'b11, 1, 1'b0);
    idle(1, 20);
    expect_frame(1, "t2_badpar", 8'h07, 1'b0, 1'b1);
    send(1, 8'h07, 1, 1'b1, 2'b11, 1, 1'b0);
    idle(1, 20);
    expect_frame(1, "t2_goodpar", 8'h07, 1'b0, 1'b0);

    // Odd parity, two stops, second stop low and line held low (break)
    send(2, 8'h3C, 2, good_parity(2, 8'h3C), 2'b01, 2, 1'b0);
    repeat (40) @(negedge clk);
    expect_frame(2, "t3_ferr", 8'h3C, 1'b1, 1'b0);
    chk("t3_busy_break", 32'(busy2), 32'd1);
    idle(2, 6);
    chk("t3_busy_released", 32'(busy2), 32'd0);

    // Short low pulse rejected as a start glitch
    put(0, 1'b0);
    repeat (4) @(negedge clk);
    put(0, 1'b1);
    repeat (2) @(negedge clk);
    chk("t4_busy_start", 32'(busy0), 32'd1);
    repeat (20) @(negedge clk);
    chk("t4_busy_back", 32'(busy0), 32'd0);
    chk("t4_no_valid", 32'(q0.size()), 32'd0);
    send(0, 8'h55, 0, 1'b0, 2'b11, 1, 1'b0);
    idle(0, 20);
    expect_frame(0, "t4_55", 8'h55, 1'b0, 1'b0);

    // Back-to-back frames with no idle gap
    send(0, 8'h01, 0, 1'b0, 2'b11, 1, 1'b0);
    send(0, 8'hFE, 0, 1'b0, 2'b11, 1, 1'b0);
    idle(0, 20);
    chk("t5_count", 32'(q0.size()), 32'd2);
    if (q0.size() == 2) begin
      chk("t5_first", 32'(q0[0]), 32'h001);
      chk("t5_second", 32'(q0[1]), 32'h0FE);
    end
    q0.delete();

    // Reset during data bit 3 of 0x81 aborts the frame
    data = 8'h81;
    for (int c = 0; c < CPB; c++) begin @(negedge clk); put(0, 1'b0); end
    for (int j = 0; j < 3; j++)
      for (int c = 0; c < CPB; c++) begin @(negedge clk); put(0, data[j]); end
    for (int c = 0; c < 6; c++) begin @(negedge clk); put(0, data[3]); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    put(0, 1'b1);
    repeat (12 * CPB) @(negedge clk);
    chk("t6_no_valid", 32'(q0.size()), 32'd0);
    chk("t6_busy", 32'(busy0), 32'd0);
    send(0, 8'h42, 0, 1'b0, 2'b11, 1, 1'b0);
    idle(0, 20);
    expect_frame(0, "t6_42", 8'h42, 1'b0, 1'b0);

    // One-cycle glitch at each data bit centre
`ifdef UART_RX_MAJORITY_EN
    glitch_exp = 8'h96;
`else
    glitch_exp = 8'h69;
`endif
    send(0, 8'h96, 0, 1'b0, 2'b11, 1, 1'b1);
    idle(0, 20);
    expect_frame(0, "t7_glitch", glitch_exp, 1'b0, 1'b0);

    // Random frames on the parity configurations against the reference rules
    for (int i = 0; i < 16; i++) begin
      d     = 1 + (i % 2);
      pmode = d;
      nstop = d;
      data  = 8'($urandom);
      bad_p = ($urandom_range(3) == 0);
      pbit  = bad_p ? ~good_parity(pmode, data) : good_parity(pmode, data);
      stops = ($urandom_range(3) == 0) ? 2'($urandom_range(2)) : 2'b11;
      exp_f = (nstop == 1) ? ~stops[0] : (stops != 2'b11);
      send(d, data, pmode, pbit, stops, nstop, 1'b0);
      idle(d, 24);
      expect_frame(d, $sformatf("rand%0d", i), data, exp_f, bad_p);
      chk($sformatf("rand%0d_busy", i), 32'(d == 1 ? busy1 : busy2), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
